// File: rtl/lsu_bus_master_if.sv
// Request/grant/rvalid data-memory bus between the LSU (master) and memory (slave).
interface lsu_bus_master_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    input  bus_gnt, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    output bus_gnt, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/lsu_bus_master.sv
// Load/store unit: turns execute-stage memory ops into bus transactions and stalls the core meanwhile.
// Optional bus-wait timeout is enabled by defining LSU_TIMEOUT_EN.
module lsu_bus_master #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   memread,
  input  logic                   memwrite,
  input  logic [2:0]             funct3,
  input  logic [31:0]            address,
  input  logic [31:0]            writedata,
  output logic                   stall,
  output logic [31:0]            readdata,
  output logic                   done,
  output logic                   err,
  lsu_bus_master_if.master       bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;

  state_t      state_q;
  logic        bus_req_q;
  logic        bus_we_q;
  logic [31:0] bus_addr_q;
  logic [31:0] bus_wdata_q;
  logic [3:0]  bus_be_q;
  logic [31:0] readdata_q;
  logic        done_q;
  logic        err_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;

  logic        access;
  logic        f3_ok;
  logic        misalign;
  logic        illegal;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic [31:0] load_val;
  logic        tmo_hit;

  always_comb begin
    access   = memread | memwrite;
    f3_ok    = memread ? (funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (funct3 < 3'd3);
    misalign = ((funct3[1:0] == 2'd1) & address[0]) |
               ((funct3[1:0] == 2'd2) & (address[1:0] != 2'd0));
    illegal  = access & ((memread & memwrite) | ~f3_ok | misalign);
  end

  always_comb begin
    be_d    = 4'b1111;
    wdata_d = writedata;
    case (funct3[1:0])
      2'd0: begin
        be_d    = 4'b0001 << address[1:0];
        wdata_d = {4{writedata[7:0]}};
      end
      2'd1: begin
        be_d    = address[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{writedata[15:0]}};
      end
      default: ;
    endcase
  end

  // Lane select and extension use the offset/size latched in IDLE, not the live core inputs.
  always_comb begin
    rbyte = bus.bus_rdata[7:0];
    case (off_q)
      2'd1:    rbyte = bus.bus_rdata[15:8];
      2'd2:    rbyte = bus.bus_rdata[23:16];
      2'd3:    rbyte = bus.bus_rdata[31:24];
      default: ;
    endcase
    rhalf = off_q[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
    case (f3_q[1:0])
      2'd0:    load_val = {{24{~f3_q[2] & rbyte[7]}}, rbyte};
      2'd1:    load_val = {{16{~f3_q[2] & rhalf[15]}}, rhalf};
      default: load_val = bus.bus_rdata;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CntW = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_inc;

  assign cnt_inc = cnt_q + 1'b1;
  assign tmo_hit = (cnt_inc == CntW'(TIMEOUT_CYC));

  always_ff @(posedge clk) begin
    if (rst || !(state_q inside {REQ, WAIT_R})) cnt_q <= '0;
    else                                        cnt_q <= cnt_inc;
  end
`else
  assign tmo_hit = 1'b0 & (TIMEOUT_CYC == 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_be_q    <= '0;
      readdata_q  <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      f3_q        <= '0;
      off_q       <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (access && !illegal) begin
            bus_req_q   <= 1'b1;
            bus_we_q    <= memwrite;
            bus_addr_q  <= {address[31:2], 2'b00};
            bus_wdata_q <= wdata_d;
            bus_be_q    <= be_d;
            f3_q        <= funct3;
            off_q       <= address[1:0];
            state_q     <= REQ;
          end
        end
        REQ: begin
          if (bus.bus_gnt) begin
            bus_req_q <= 1'b0;
            if (bus_we_q) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              state_q <= WAIT_R;
            end
          end else if (tmo_hit) begin
            bus_req_q  <= 1'b0;
            done_q     <= 1'b1;
            err_q      <= 1'b1;
            readdata_q <= '0;
            state_q    <= DONE;
          end
        end
        WAIT_R: begin
          if (bus.bus_rvalid) begin
            readdata_q <= load_val;
            done_q     <= 1'b1;
            state_q    <= DONE;
          end else if (tmo_hit) begin
            done_q     <= 1'b1;
            err_q      <= 1'b1;
            readdata_q <= '0;
            state_q    <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stall          = access & (state_q != DONE) & ~illegal & ~rst;
  assign err            = err_q | ((state_q == IDLE) & illegal & ~rst);
  assign done           = done_q;
  assign readdata       = readdata_q;
  assign bus.bus_req    = bus_req_q;
  assign bus.bus_we     = bus_we_q;
  assign bus.bus_addr   = bus_addr_q;
  assign bus.bus_wdata  = bus_wdata_q;
  assign bus.bus_be     = bus_be_q;

endmodule

// File: tb/tb_lsu_bus_master.sv
// Directed bench for lsu_bus_master: stores, loads with extension, illegal accesses, wait states, reset.
module tb_lsu_bus_master;

  logic        clk;
  logic        rst;
  logic        memread;
  logic        memwrite;
  logic [2:0]  funct3;
  logic [31:0] address;
  logic [31:0] writedata;
  logic        stall;
  logic [31:0] readdata;
  logic        done;
  logic        err;

  int unsigned checks = 0;
  int unsigned errors = 0;

  lsu_bus_master_if bif ();

  lsu_bus_master #(.TIMEOUT_CYC(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .memread   (memread),
    .memwrite  (memwrite),
    .funct3    (funct3),
    .address   (address),
    .writedata (writedata),
    .stall     (stall),
    .readdata  (readdata),
    .done      (done),
    .err       (err),
    .bus       (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic do_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] ebe, input logic [31:0] ewd, input string tag);
    nxt();
    memwrite = 1'b1; funct3 = f3; address = a; writedata = wd;
    smp();
    chk({tag, "_c0_stall"}, stall, 1);
    chk({tag, "_c0_req"}, bif.bus_req, 0);
    nxt();
    bif.bus_gnt = 1'b1;
    smp();
    chk({tag, "_req"}, bif.bus_req, 1);
    chk({tag, "_addr"}, bif.bus_addr, {a[31:2], 2'b00});
    chk({tag, "_be"}, bif.bus_be, ebe);
    chk({tag, "_we"}, bif.bus_we, 1);
    chk({tag, "_wdata"}, bif.bus_wdata, ewd);
    chk({tag, "_c1_stall"}, stall, 1);
    chk({tag, "_c1_done"}, done, 0);
    nxt();
    bif.bus_gnt = 1'b0;
    smp();
    chk({tag, "_done"}, done, 1);
    chk({tag, "_c2_stall"}, stall, 0);
    chk({tag, "_c2_req"}, bif.bus_req, 0);
    nxt();
    memwrite = 1'b0;
    smp();
    chk({tag, "_done_pulse"}, done, 0);
  endtask

  task automatic do_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd,
                         input logic [3:0] ebe, input logic [31:0] erd, input string tag);
    nxt();
    memread = 1'b1; funct3 = f3; address = a;
    smp();
    chk({tag, "_c0_stall"}, stall, 1);
    nxt();
    bif.bus_gnt = 1'b1;
    smp();
    chk({tag, "_req"}, bif.bus_req, 1);
    chk({tag, "_addr"}, bif.bus_addr, {a[31:2], 2'b00});
    chk({tag, "_be"}, bif.bus_be, ebe);
    chk({tag, "_we"}, bif.bus_we, 0);
    nxt();
    bif.bus_gnt = 1'b0; bif.bus_rvalid = 1'b1; bif.bus_rdata = rd;
    smp();
    chk({tag, "_c2_stall"}, stall, 1);
    chk({tag, "_c2_done"}, done, 0);
    chk({tag, "_c2_req"}, bif.bus_req, 0);
    nxt();
    bif.bus_rvalid = 1'b0; bif.bus_rdata = 32'h5A5A_5A5A;
    smp();
    chk({tag, "_done"}, done, 1);
    chk({tag, "_rdata"}, readdata, erd);
    chk({tag, "_c3_stall"}, stall, 0);
    nxt();
    memread = 1'b0;
    smp();
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_rdata_hold"}, readdata, erd);
  endtask

  task automatic do_illegal(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] a, input string tag);
    nxt();
    memread = rd; memwrite = wr; funct3 = f3; address = a;
    smp();
    chk({tag, "_err"}, err, 1);
    chk({tag, "_stall"}, stall, 0);
    chk({tag, "_req"}, bif.bus_req, 0);
    nxt();
    memread = 1'b0; memwrite = 1'b0;
    smp();
    chk({tag, "_err_clr"}, err, 0);
    chk({tag, "_req_after"}, bif.bus_req, 0);
    chk({tag, "_no_done"}, done, 0);
  endtask

  initial begin
    rst = 1'b1; memread = 1'b0; memwrite = 1'b1; funct3 = 3'd2;
    address = 32'h10; writedata = '0;
    bif.bus_gnt = 1'b0; bif.bus_rvalid = 1'b0; bif.bus_rdata = '0;

    smp();
    chk("rst_stall", stall, 0);
    nxt();
    smp();
    chk("rst_req", bif.bus_req, 0);
    chk("rst_we", bif.bus_we, 0);
    chk("rst_addr", bif.bus_addr, 0);
    chk("rst_wdata", bif.bus_wdata, 0);
    chk("rst_be", bif.bus_be, 0);
    chk("rst_rdata", readdata, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    nxt();
    rst = 1'b0; memwrite = 1'b0;
    smp();
    chk("idle_stall", stall, 0);

    do_store(3'd2, 32'h10, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF, "sw");
    do_load (3'd0, 32'h13, 32'h80FF_7F01, 4'b1000, 32'hFFFF_FF80, "lb");
    do_load (3'd4, 32'h13, 32'h80FF_7F01, 4'b1000, 32'h0000_0080, "lbu");
    do_load (3'd1, 32'h12, 32'h8001_7FFF, 4'b1100, 32'hFFFF_8001, "lh");
    do_load (3'd5, 32'h10, 32'h8001_7FFF, 4'b0011, 32'h0000_7FFF, "lhu");
    do_store(3'd0, 32'h11, 32'h1234_5678, 4'b0010, 32'h7878_7878, "sb");
    do_store(3'd1, 32'h22, 32'h0000_ABCD, 4'b1100, 32'hABCD_ABCD, "sh");
    chk("store_keeps_rdata", readdata, 32'h0000_7FFF);

    do_illegal(1'b1, 1'b0, 3'd2, 32'h06, "ill_lw_mis");
    do_illegal(1'b1, 1'b1, 3'd0, 32'h00, "ill_both");
    do_illegal(1'b1, 1'b0, 3'd3, 32'h00, "ill_ld_f3");
    do_illegal(1'b0, 1'b1, 3'd4, 32'h00, "ill_st_f3");
    do_illegal(1'b1, 1'b0, 3'd1, 32'h21, "ill_lh_mis");

    // lw with grant in the 6th REQ cycle, a stray rvalid during REQ, rvalid in the 3rd WAIT_R cycle
    nxt();
    memread = 1'b1; funct3 = 3'd2; address = 32'h40;
    smp();
    chk("dly_c0_stall", stall, 1);
    for (int i = 1; i <= 6; i++) begin
      nxt();
      bif.bus_rvalid = (i == 2);
      bif.bus_rdata  = 32'hBAD0_BAD0;
      bif.bus_gnt    = (i == 6);
      smp();
      chk("dly_req", bif.bus_req, 1);
      chk("dly_addr", bif.bus_addr, 32'h40);
      chk("dly_be", bif.bus_be, 4'b1111);
      chk("dly_stall", stall, 1);
      chk("dly_done", done, 0);
    end
    for (int j = 1; j <= 3; j++) begin
      nxt();
      bif.bus_gnt    = 1'b0;
      bif.bus_rvalid = (j == 3);
      bif.bus_rdata  = 32'hCAFE_F00D;
      smp();
      chk("dly_w_req", bif.bus_req, 0);
      chk("dly_w_stall", stall, 1);
      chk("dly_w_done", done, 0);
    end
    nxt();
    bif.bus_rvalid = 1'b0; bif.bus_rdata = '0;
    smp();
    chk("dly_done_set", done, 1);
    chk("dly_rdata", readdata, 32'hCAFE_F00D);
    nxt();
    memread = 1'b0;
    smp();
    chk("dly_done_clr", done, 0);

`ifdef LSU_TIMEOUT_EN
    nxt();
    memread = 1'b1; funct3 = 3'd2; address = 32'h80;
    smp();
    for (int k = 1; k <= 4; k++) begin
      nxt();
      smp();
      chk("tmo_req", bif.bus_req, 1);
      chk("tmo_wait_done", done, 0);
    end
    nxt();
    smp();
    chk("tmo_done", done, 1);
    chk("tmo_err", err, 1);
    chk("tmo_rdata", readdata, 0);
    chk("tmo_req_drop", bif.bus_req, 0);
    nxt();
    memread = 1'b0;
    smp();
    chk("tmo_done_clr", done, 0);
    chk("tmo_err_clr", err, 0);
    chk("tmo_req_idle", bif.bus_req, 0);
`endif

    // reset in WAIT_R, then a late rvalid must be ignored
    nxt();
    memread = 1'b1; funct3 = 3'd2; address = 32'h44;
    smp();
    nxt();
    bif.bus_gnt = 1'b1;
    smp();
    chk("rwr_req", bif.bus_req, 1);
    nxt();
    bif.bus_gnt = 1'b0; rst = 1'b1;
    smp();
    chk("rwr_stall_rst", stall, 0);
    nxt();
    rst = 1'b0; memread = 1'b0;
    bif.bus_rvalid = 1'b1; bif.bus_rdata = 32'h1111_1111;
    smp();
    chk("rwr_req_idle", bif.bus_req, 0);
    chk("rwr_done0", done, 0);
    chk("rwr_stall", stall, 0);
    nxt();
    bif.bus_rvalid = 1'b0;
    smp();
    chk("rwr_late_done", done, 0);
    chk("rwr_rdata", readdata, 0);
    chk("rwr_req_after", bif.bus_req, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
